nes_controller_responder: RTL and testbench
===========================================

# nes_controller_responder

Emulates the controller end of the NES serial controller interface, acting as a parallel-in/serial-out register in the style of the 4021. It receives the console's latch and pulse lines and drives the serial data line from an 8-bit button vector. It is the responder to our existing host-side shift-register reader, so the two blocks can be bench-tested back to back. All console-side inputs are asynchronous to `clk` and are synchronized internally.

## Interface
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a pulse rising edge, while in SHIFTING or DONE, before the block returns to IDLE.
- `FILL_BIT`, default 1'b0: wire level driven on `sout` after all 8 bits have been shifted out.
- `clk`, input, 1: single system clock. All flops are rising-edge.
- `reset`, input, 1: asynchronous, active-low. Asserting it immediately forces every flop to its reset value.
- `latch`, input, 1: console latch line, asynchronous. Active-high.
- `pulse`, input, 1: console clock line, asynchronous. Action is taken on its rising edge.
- `buttons`, input, 8: pressed = 1. Bit order: [7]=A, [6]=B, [5]=Select, [4]=Start, [3]=Up, [2]=Down, [1]=Left, [0]=Right.
- `sout`, output, 1: serial data line, wire-level active-low (pressed = 0). Registered. Reset value 1.
- `state`, output, 2: FSM state. Reset value IDLE (2'd0).
- `bitIdx`, output, 4: index of the bit currently on `sout`, range 0..8. Reset value 0.
- `frameDone`, output, 1: one-cycle pulse when the 8th bit is shifted past. Reset value 0.
- `timeout`, output, 1: sticky flag, cleared on the next latch rise. Reset value 0.

## Operation
- `latch` and `pulse` each pass through a 2-flop synchronizer followed by an edge detector that produces `rise` and `fall`. The FSM acts on the synchronized signals only.
- States: IDLE=0, LOADED=1, SHIFTING=2, DONE=3.
- IDLE:
  - `sout`=1.
  - On latch rise: go to LOADED, load shreg=~buttons, set bitIdx=0, clear timeout.
- LOADED (parallel mode):
  - shreg reloads from ~buttons every cycle.
  - `sout`=shreg[7], so A appears on the line.
  - Pulse rises are ignored.
  - On latch fall: shreg is not reloaded that cycle and holds the value loaded on the previous cycle. Go to SHIFTING.
- SHIFTING:
  - On pulse rise: shreg <= {shreg[6:0], FILL_BIT}, bitIdx++, and `sout` takes the new shreg[7].
  - When bitIdx goes 7→8: assert frameDone for one cycle, go to DONE.
- DONE:
  - `sout`=FILL_BIT. Further pulse rises change nothing; bitIdx saturates at 8.
- Latch rise in any state: abort the current frame and re-enter LOADED. This takes priority over a simultaneous pulse rise.
- Timeout:
  - The counter is cleared on entry to SHIFTING and on every pulse rise. It counts only in SHIFTING or DONE.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE and set `timeout`=1.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Changes on `buttons` are ignored outside LOADED.
- Reset asserted mid-frame: `sout` goes to 1 immediately. After reset releases, the block waits in IDLE for a fresh latch rise.

## Timing
- Console pin transitions are first sampled at rising edge k. The corresponding `sout`, `state` and `bitIdx` update lands at edge k+2.
- Required minimum high and low width on `latch` and `pulse`: 3 `clk` cycles. Narrower pulses may be missed.
- Required: the console must not sample data sooner than 3 `clk` cycles after a pulse rising edge. At 50 MHz this is 60 ns, against 6 µs in the NES protocol.
- `frameDone` is asserted in the same cycle that `state` becomes DONE.
- A latch fall and a pulse rise detected in the same cycle: only the latch fall is taken. The bit index stays at 0.

## Structure
- Package `nes_pkg` holds:
  - the `state_t` enum (IDLE, LOADED, SHIFTING, DONE);
  - `NUM_BUTTONS=8`;
  - the button index constants `BTN_A`..`BTN_RIGHT` (A=7 … Right=0).
- The host reader imports the same package.
- One sub-module, `nes_sync_edge`: 2-flop synchronizer plus edge detector, with outputs `lvl`, `rise` and `fall`. Reset is asynchronous active-low and resets to 0. It is instantiated once for `latch` and once for `pulse`.

## Test plan
- **Full 8-bit read:** after reset, hold buttons=8'b1000_0001, latch 12 cycles, then 8 pulses. Expected: `sout` sequence 0,1,1,1,1,1,1,0; frameDone pulses once; state=DONE; bitIdx=8.
- **Reads past the 8th bit:** continue with 3 extra pulses, FILL_BIT=0. Expected: `sout` stays 0 and bitIdx stays 8.
- **Re-latch mid-frame:** buttons=8'hFF, 3 pulses shifted, then latch rises. Expected: state=LOADED, bitIdx=0, `sout`=0 (A pressed) within 2 edges of the latch sample.
- **Buttons change during and after latch:** change buttons from 8'h00 to 8'h80 while latch is high, then change them back to 8'h00 after latch falls. Expected: first bit on `sout` is 0, i.e. the value captured during latch is used.
- **Timeout:** TIMEOUT_CYCLES=100, latch, 2 pulses, then idle for 100 cycles. Expected: state=IDLE, timeout=1, `sout`=1. A following latch clears timeout.
- **Reset and glitches:**
  - Assert reset mid-SHIFTING. Expected: `sout`=1, state=IDLE and bitIdx=0 without waiting for a clock edge.
  - Drive a 1-cycle glitch on `pulse`. Expected: tolerated; bitIdx is unchanged or advances by at most 1.

Source files
------------

// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared types and constants for the NES controller interface
package nes_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOADED   = 2'd1,
        SHIFTING = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int NUM_BUTTONS = 8;

    // Bit positions inside the button vector; A is shifted out first.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_sync_edge.sv
// rtl/nes_sync_edge.sv - 2-flop synchronizer with rise/fall edge detect
module nes_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-stage synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign lvl  = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/nes_controller_responder.sv
// rtl/nes_controller_responder.sv - controller-side 4021-style serial responder
module nes_controller_responder
    import nes_pkg::*;
#(
    parameter int   TIMEOUT_CYCLES = 50000,
    parameter logic FILL_BIT       = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   latch,
    input  logic                   pulse,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic                   sout,
    output logic [1:0]             state,
    output logic [3:0]             bitIdx,
    output logic                   frameDone,
    output logic                   timeout
);

    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic latch_lvl, latch_rise, latch_fall;
    logic pulse_lvl, pulse_rise, pulse_fall;
    logic unused_sink;

    state_t                 state_q, state_d;
    logic [NUM_BUTTONS-1:0] shreg_q, shreg_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic                   sout_q, sout_d;
    logic                   frame_done_q, frame_done_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    nes_sync_edge u_latch_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (latch),
        .lvl   (latch_lvl),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    nes_sync_edge u_pulse_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (pulse),
        .lvl   (pulse_lvl),
        .rise  (pulse_rise),
        .fall  (pulse_fall)
    );

    // Only edges drive the FSM; the remaining synchronizer outputs are unused.
    assign unused_sink = ^{latch_lvl, pulse_lvl, pulse_fall};

    // Next-state logic: latch rise overrides everything, then per-state behaviour.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        sout_d       = sout_q;
        frame_done_d = 1'b0;
        timeout_d    = timeout_q;
        cnt_d        = cnt_q;

        if (latch_rise) begin
            state_d   = LOADED;
            shreg_d   = ~buttons;
            sout_d    = ~buttons[BTN_A];
            bit_idx_d = 4'd0;
            timeout_d = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    sout_d = 1'b1;
                end
                LOADED: begin
                    // On the fall the register keeps last cycle's snapshot.
                    if (latch_fall) begin
                        state_d = SHIFTING;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = ~buttons;
                        sout_d  = ~buttons[BTN_A];
                    end
                end
                SHIFTING: begin
                    if (pulse_rise) begin
                        shreg_d   = {shreg_q[NUM_BUTTONS-2:0], FILL_BIT};
                        sout_d    = shreg_q[NUM_BUTTONS-2];
                        bit_idx_d = bit_idx_q + 4'd1;
                        cnt_d     = '0;
                        if (bit_idx_q == 4'd7) begin
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        sout_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    sout_d = FILL_BIT;
                    if (pulse_rise) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                        sout_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    sout_d  = 1'b1;
                end
            endcase
        end
    end

    // State registers; reset drops the line to idle-high immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shreg_q      <= '1;
            bit_idx_q    <= 4'd0;
            sout_q       <= 1'b1;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            sout_q       <= sout_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sout      = sout_q;
    assign state     = state_q;
    assign bitIdx    = bit_idx_q;
    assign frameDone = frame_done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
// tb/tb_nes_controller_responder.sv - randomized self-checking bench for the NES responder
module tb_nes_controller_responder;

    localparam int   TO   = 100;
    localparam logic FILL = 1'b0;

    logic       clk;
    logic       reset;
    logic       latch;
    logic       pulse;
    logic [7:0] buttons;
    logic       sout;
    logic [1:0] state;
    logic [3:0] bitIdx;
    logic       frameDone;
    logic       timeout;

    int errors   = 0;
    int checks   = 0;
    int fd_count = 0;

    // Reference model: captured button byte and number of bits consumed.
    logic [7:0] cap;
    int         idx;

    nes_controller_responder #(
        .TIMEOUT_CYCLES (TO),
        .FILL_BIT       (FILL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .latch     (latch),
        .pulse     (pulse),
        .buttons   (buttons),
        .sout      (sout),
        .state     (state),
        .bitIdx    (bitIdx),
        .frameDone (frameDone),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frameDone === 1'b1) fd_count++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic exp_sout();
        return (idx < 8) ? ~cap[7 - idx] : FILL;
    endfunction

    function automatic logic [1:0] exp_state();
        return (idx < 8) ? 2'd2 : 2'd3;
    endfunction

    task automatic check_line(input string tag);
        chk({tag, ".sout"},   32'(sout),   32'(exp_sout()));
        chk({tag, ".state"},  32'(state),  32'(exp_state()));
        chk({tag, ".bitIdx"}, 32'(bitIdx), 32'(idx));
    endtask

    task automatic latch_frame(input logic [7:0] b, input int hold);
        buttons = b;
        latch   = 1'b1;
        cyc(hold);
        latch   = 1'b0;
        cyc(4);
        cap = b;
        idx = 0;
    endtask

    task automatic pulse_once();
        pulse = 1'b1;
        cyc(4);
        pulse = 1'b0;
        cyc(4);
        if (idx < 8) idx++;
    endtask

    initial begin
        int         fd0;
        logic [7:0] seq;
        logic [7:0] b;
        int         np;

        reset   = 1'b0;
        latch   = 1'b0;
        pulse   = 1'b0;
        buttons = 8'h00;
        cap     = 8'h00;
        idx     = 0;
        cyc(3);
        chk("rst.sout",      32'(sout),      32'd1);
        chk("rst.state",     32'(state),     32'd0);
        chk("rst.bitIdx",    32'(bitIdx),    32'd0);
        chk("rst.frameDone", 32'(frameDone), 32'd0);
        chk("rst.timeout",   32'(timeout),   32'd0);
        reset = 1'b1;
        cyc(3);
        chk("idle.sout", 32'(sout), 32'd1);

        // Full 8-bit read of A and Right pressed.
        fd0 = fd_count;
        latch_frame(8'b1000_0001, 12);
        check_line("full.b0");
        seq[7] = sout;
        for (int i = 1; i <= 8; i++) begin
            pulse_once();
            check_line($sformatf("full.p%0d", i));
            if (i < 8) seq[7 - i] = sout;
        end
        chk("full.seq",       32'(seq),            32'h7E);
        chk("full.frameDone", 32'(fd_count - fd0), 32'd1);

        // Reads past the last bit.
        for (int i = 0; i < 3; i++) begin
            pulse_once();
            check_line($sformatf("past.p%0d", i));
        end
        chk("past.frameDone", 32'(fd_count - fd0), 32'd1);

        // Re-latch mid-frame with everything pressed.
        latch_frame(8'hFF, 5);
        for (int i = 0; i < 3; i++) pulse_once();
        check_line("relatch.pre");
        latch = 1'b1;
        cyc(3);
        chk("relatch.state",  32'(state),  32'd1);
        chk("relatch.bitIdx", 32'(bitIdx), 32'd0);
        chk("relatch.sout",   32'(sout),   32'd0);
        latch = 1'b0;
        cyc(4);
        cap = 8'hFF;
        idx = 0;
        check_line("relatch.post");

        // Buttons change while latch high, then revert after the fall.
        buttons = 8'h00;
        latch   = 1'b1;
        cyc(2);
        buttons = 8'h80;
        cyc(3);
        latch   = 1'b0;
        cyc(5);
        buttons = 8'h00;
        cyc(2);
        cap = 8'h80;
        idx = 0;
        check_line("btnchg.b0");
        pulse_once();
        check_line("btnchg.p1");

        // Inactivity timeout.
        latch_frame(8'h5A, 4);
        pulse_once();
        pulse_once();
        cyc(85);
        chk("to.early.state",   32'(state),   32'd2);
        chk("to.early.timeout", 32'(timeout), 32'd0);
        cyc(15);
        chk("to.state",   32'(state),   32'd0);
        chk("to.timeout", 32'(timeout), 32'd1);
        chk("to.sout",    32'(sout),    32'd1);
        buttons = 8'h00;
        latch   = 1'b1;
        cyc(3);
        chk("to.clr.timeout", 32'(timeout), 32'd0);
        chk("to.clr.state",   32'(state),   32'd1);
        latch = 1'b0;
        cyc(4);

        // Asynchronous reset mid-shift.
        latch_frame(8'hC3, 4);
        pulse_once();
        pulse_once();
        pulse_once();
        check_line("ares.pre");
        #2 reset = 1'b0;
        #1;
        chk("ares.sout",   32'(sout),   32'd1);
        chk("ares.state",  32'(state),  32'd0);
        chk("ares.bitIdx", 32'(bitIdx), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        pulse_once();
        pulse_once();
        chk("ares.wait.state",  32'(state),  32'd0);
        chk("ares.wait.sout",   32'(sout),   32'd1);
        chk("ares.wait.bitIdx", 32'(bitIdx), 32'd0);

        // One-cycle glitch on pulse.
        latch_frame(8'h3C, 4);
        pulse_once();
        pulse_once();
        pulse = 1'b1;
        cyc(1);
        pulse = 1'b0;
        cyc(6);
        chk("glitch.bitIdx", 32'((bitIdx == 4'(idx)) || (bitIdx == 4'(idx + 1))), 32'd1);

        // Randomized frames with buttons churning after capture.
        for (int f = 0; f < 12; f++) begin
            b   = 8'($urandom);
            np  = $urandom_range(0, 11);
            fd0 = fd_count;
            latch_frame(b, $urandom_range(3, 8));
            check_line($sformatf("rnd%0d.b0", f));
            for (int p = 0; p < np; p++) begin
                buttons = 8'($urandom);
                pulse_once();
                check_line($sformatf("rnd%0d.p%0d", f, p + 1));
            end
            chk($sformatf("rnd%0d.frameDone", f), 32'(fd_count - fd0), (np >= 8) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
